// File: rtl/digit_scan_ctrl.sv
// rtl/digit_scan_ctrl.sv - two-digit common-anode scan scheduler with blanking
//
// Purpose:
//   Time-multiplexes one shared hex-to-seven-segment decoder and segment bus
//   across two common-anode digits. Each digit is preceded by a blanking
//   interval with both anodes off, so the new nibble never drives the
//   previous digit's anode (no ghosting).
//   The scan order is:
//     BLANK0 -> SHOW0 -> BLANK1 -> SHOW1 -> BLANK0 ...
//
// Parameters:
//   ON_CYCLES     cycles each digit is lit per scan (>= 1)
//   BLANK_CYCLES  cycles both anodes are off before each digit (>= 1)
//   CNT_W         phase counter width; holds max(ON_CYCLES, BLANK_CYCLES)-1
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   en            scan enable; low blanks the display and parks the scan at BLANK0
//   s0, s1        hex values for digit 0 / digit 1
//   nib           nibble to the shared segment decoder
//   an            active-low anode enables, an[0] = digit 0, an[1] = digit 1
//   digit_strobe  one-cycle pulse on the first lit cycle of each digit
//   active_digit  index of the digit being or last driven

module digit_scan_ctrl #(
  parameter int ON_CYCLES    = 20000,
  parameter int BLANK_CYCLES = 200,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [3:0] nib,
  output logic [1:0] an,
  output logic       digit_strobe,
  output logic       active_digit
);

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // The counter only ever counts up to the last cycle of the current state
  // and is cleared on every state change, so it can never overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= BLANK0;
      cnt          <= '0;
      an           <= 2'b11;
      nib          <= 4'h0;
      digit_strobe <= 1'b0;
      active_digit <= 1'b0;
    end else if (!en) begin
      // Park at the start of the scan; nib/active_digit keep their last value.
      state        <= BLANK0;
      cnt          <= '0;
      an           <= 2'b11;
      digit_strobe <= 1'b0;
    end else begin
      digit_strobe <= 1'b0;
      case (state)
        BLANK0: begin
          if (cnt == BLANK_LAST) begin
            state        <= SHOW0;
            cnt          <= '0;
            an           <= 2'b10;
            nib          <= s0;
            active_digit <= 1'b0;
            digit_strobe <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW0: begin
          if (cnt == ON_LAST) begin
            state <= BLANK1;
            cnt   <= '0;
            an    <= 2'b11;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BLANK1: begin
          if (cnt == BLANK_LAST) begin
            state        <= SHOW1;
            cnt          <= '0;
            an           <= 2'b01;
            nib          <= s1;
            active_digit <= 1'b1;
            digit_strobe <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW1: begin
          if (cnt == ON_LAST) begin
            state <= BLANK0;
            cnt   <= '0;
            an    <= 2'b11;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= BLANK0;
          cnt   <= '0;
          an    <= 2'b11;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb/tb_digit_scan_ctrl.sv - scoreboard bench for digit_scan_ctrl

module tb_digit_scan_ctrl;

  localparam int ON  = 4;
  localparam int BL  = 2;
  localparam int PER = 2 * (ON + BL);

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] s0;
  logic [3:0] s1;
  logic [3:0] nib;
  logic [1:0] an;
  logic       digit_strobe;
  logic       active_digit;

  int cmp_cnt = 0;
  int err_cnt = 0;

  digit_scan_ctrl #(
    .ON_CYCLES   (ON),
    .BLANK_CYCLES(BL),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .s0          (s0),
    .s1          (s1),
    .nib         (nib),
    .an          (an),
    .digit_strobe(digit_strobe),
    .active_digit(active_digit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0] an;
    logic [3:0] nib;
    logic       st;
    logic       act;
    logic       cut;
  } exp_t;

  exp_t sb[$];

  // Reference model: a position within the 12-cycle scan period.
  int         m_pos;
  logic [3:0] m_nib;
  logic       m_act;
  logic       m_st;
  logic [1:0] m_an;
  logic       cut_pend;

  function automatic logic [1:0] an_of(input int pos);
    if (pos >= BL && pos < BL + ON)  return 2'b10;
    if (pos >= 2 * BL + ON)          return 2'b01;
    return 2'b11;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pos    = 0;
      m_nib    = 4'h0;
      m_act    = 1'b0;
      m_st     = 1'b0;
      m_an     = 2'b11;
      cut_pend = 1'b1;
      sb.delete();
    end else begin
      m_st = 1'b0;
      if (!en) begin
        m_pos    = 0;
        cut_pend = 1'b1;
      end else begin
        m_pos = (m_pos + 1) % PER;
        if (m_pos == BL) begin
          m_nib = s0;
          m_act = 1'b0;
          m_st  = 1'b1;
        end else if (m_pos == 2 * BL + ON) begin
          m_nib = s1;
          m_act = 1'b1;
          m_st  = 1'b1;
        end
      end
      m_an = an_of(m_pos);
      sb.push_back('{an: m_an, nib: m_nib, st: m_st, act: m_act, cut: cut_pend});
      cut_pend = 1'b0;
    end
  end

  // Output checker, sampling on the falling edge.
  exp_t e;
  logic prev_st  = 1'b0;
  int   show_len = 0;
  logic cut      = 1'b1;

  always @(negedge clk) begin
    if (!reset && sb.size() != 0) begin
      e = sb.pop_front();
      if (e.cut) cut = 1'b1;
      chk("an", 16'(an), 16'(e.an));
      chk("nib", 16'(nib), 16'(e.nib));
      chk("strobe", 16'(digit_strobe), 16'(e.st));
      chk("active_digit", 16'(active_digit), 16'(e.act));
      chk("an_never_00", 16'(an == 2'b00), 16'd0);
      chk("strobe_twice", 16'(prev_st & digit_strobe), 16'd0);
      prev_st = digit_strobe;
      if (an != 2'b11) begin
        if (digit_strobe) begin
          show_len = 1;
          cut      = 1'b0;
        end else begin
          show_len++;
        end
      end else begin
        if (show_len != 0 && !cut) chk("show_len", 16'(show_len), 16'(ON));
        show_len = 0;
      end
    end
  end

  task automatic edge_chk();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_show(input logic dig);
    int n;
    n = 0;
    do begin
      edge_chk();
      n++;
    end while (!(digit_strobe && active_digit == dig) && n < 40);
    chk("wait_show_timeout", 16'(n >= 40), 16'd0);
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    s0    = 4'h3;
    s1    = 4'hA;
    #3 reset = 1'b1;
    #1;
    chk("rst_an", 16'(an), 16'h3);
    chk("rst_nib", 16'(nib), 16'h0);
    chk("rst_strobe", 16'(digit_strobe), 16'h0);
    chk("rst_act", 16'(active_digit), 16'h0);
    repeat (2) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;

    // Basic scan anchors, counting edges after reset release.
    for (int k = 1; k <= 14; k++) begin
      edge_chk();
      case (k)
        1:  chk("scan_e1_an", 16'(an), 16'h3);
        2:  begin
              chk("scan_e2_an", 16'(an), 16'h2);
              chk("scan_e2_st", 16'(digit_strobe), 16'h1);
              chk("scan_e2_nib", 16'(nib), 16'h3);
            end
        3:  chk("scan_e3_st", 16'(digit_strobe), 16'h0);
        6:  chk("scan_e6_an", 16'(an), 16'h3);
        8:  begin
              chk("scan_e8_an", 16'(an), 16'h1);
              chk("scan_e8_nib", 16'(nib), 16'hA);
              chk("scan_e8_act", 16'(active_digit), 16'h1);
            end
        12: chk("scan_e12_an", 16'(an), 16'h3);
        14: chk("scan_e14_an", 16'(an), 16'h2);
        default: ;
      endcase
    end

    // Change s0 during the second SHOW0 cycle: not visible until next SHOW0.
    edge_chk();
    @(negedge clk);
    s0 = 4'h7;
    edge_chk();
    chk("stable_nib", 16'(nib), 16'h3);
    wait_show(1'b1);
    chk("stable_nib1", 16'(nib), 16'hA);
    wait_show(1'b0);
    chk("stable_nib_new", 16'(nib), 16'h7);

    // Enable drop during SHOW1 cycle 2.
    wait_show(1'b1);
    edge_chk();
    @(negedge clk);
    en = 1'b0;
    edge_chk();
    chk("endrop_an", 16'(an), 16'h3);
    chk("endrop_st", 16'(digit_strobe), 16'h0);
    chk("endrop_nib", 16'(nib), 16'hA);
    repeat (5) begin
      edge_chk();
      chk("enlow_an", 16'(an), 16'h3);
    end
    @(negedge clk);
    en = 1'b1;
    edge_chk();
    chk("enup_e1_an", 16'(an), 16'h3);
    edge_chk();
    chk("enup_e2_an", 16'(an), 16'h2);
    chk("enup_e2_st", 16'(digit_strobe), 16'h1);

    // Reset pulse during SHOW0.
    wait_show(1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_an", 16'(an), 16'h3);
    chk("midrst_nib", 16'(nib), 16'h0);
    chk("midrst_st", 16'(digit_strobe), 16'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    edge_chk();
    chk("midrst_e1_an", 16'(an), 16'h3);
    edge_chk();
    chk("midrst_e2_an", 16'(an), 16'h2);
    chk("midrst_e2_st", 16'(digit_strobe), 16'h1);

    // Random soak with occasional short reset pulses.
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      s0 = 4'($urandom_range(15, 0));
      s1 = 4'($urandom_range(15, 0));
      en = ($urandom_range(15, 0) != 0);
      if ($urandom_range(199, 0) == 0) begin
        #2 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
